// File: rtl/fir_pkg.sv
// Shared FIR datapath widths and saturation bounds used by the filter and its output stages.
package fir_pkg;

    localparam int FIR_SAMPLE_W = 16;
    localparam int FIR_OUT_W    = 8;

    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous FIFO with a combinational head; a write at full is accepted only alongside a pop.
module fir_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              do_wr;
    logic              do_rd;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_decim_out.sv
// FIR output stage: decimate, requantize (shift + saturate), buffer in a FIFO with valid/ready drain.
// Define FIR_DECIM_ROUND_EN for round-half-up before the shift; default build truncates (floor).
module fir_decim_out
    import fir_pkg::*;
#(
    parameter int IN_W       = FIR_SAMPLE_W,
    parameter int OUT_W      = FIR_OUT_W,
    parameter int DECIM      = 4,
    parameter int SHIFT      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             sat_pulse,
    output logic             overflow
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
    localparam logic signed [IN_W:0] QMAX = (IN_W + 1)'(sat_max(OUT_W));
    localparam logic signed [IN_W:0] QMIN = (IN_W + 1)'(sat_min(OUT_W));
`ifdef FIR_DECIM_ROUND_EN
    localparam logic signed [IN_W:0] RND = (IN_W + 1)'(1) << (SHIFT - 1);
`endif

    logic [PH_W-1:0]    phase;
    logic               keep;
    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] biased;
    logic signed [IN_W:0] shifted;
    logic               clip;
    logic [OUT_W-1:0]   q;
    logic               stage_valid;
    logic [OUT_W-1:0]   stage_data;
    logic [OUT_W-1:0]   fifo_head;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop;

    assign keep = in_valid && (phase == '0);

    // Work one bit wider than the input so the rounding bias cannot wrap.
    always_comb begin
        ext = {in_data[IN_W-1], in_data};
`ifdef FIR_DECIM_ROUND_EN
        biased = ext + RND;
`else
        biased = ext;
`endif
        shifted = biased >>> SHIFT;
        clip    = 1'b0;
        q       = shifted[OUT_W-1:0];
        if (shifted > QMAX) begin
            clip = 1'b1;
            q    = QMAX[OUT_W-1:0];
        end else if (shifted < QMIN) begin
            clip = 1'b1;
            q    = QMIN[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase       <= '0;
            stage_valid <= 1'b0;
            stage_data  <= '0;
            sat_pulse   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (in_valid) begin
                phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            end
            stage_valid <= keep;
            sat_pulse   <= keep && clip;
            if (keep) begin
                stage_data <= q;
            end
            if (stage_valid && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign pop = out_valid && out_ready;

    fir_out_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (stage_valid),
        .wr_data (stage_data),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Memory is not cleared by reset, so mask the head while empty.
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_head;

endmodule
